fpu_ftoi: RTL

Multi-cycle float-to-integer converter, the inverse of the FPU's itof path. Converts a 16-bit PinKY float (sign[15], exp[14:7] biased by 127, mant[6:0] with an implied leading 1) to a 16-bit two's-complement integer. It sits beside the itof datapath inside the FPU. Stage 3 drives it with the same en/done stall handshake: the pipeline freezes while done=0.

---
 rtl/fpu_ftoi_pkg.sv | 38 +++
 rtl/fpu_ftoi_align.sv | 59 +++++
 rtl/fpu_ftoi.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fpu_ftoi_pkg.sv
// FPU constants: float fields, opcodes, ftoi FSM states, saturation bounds.
package fpu_ftoi_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_HI   = 14;
  localparam int EXP_LO   = 7;
  localparam int MANT_HI  = 6;
  localparam int MANT_LO  = 0;

  localparam int EXP_BIAS = 127;
  localparam int INT_W    = 16;

  localparam logic [15:0] INT_MAX = 16'h7FFF;
  localparam logic [15:0] INT_MIN = 16'h8000;

  typedef enum logic [3:0] {
    OPitof = 4'd10,
    OPftoi = 4'd11
  } fpu_op_e;

  // ftoi states sit in the 16..20 block after the itof states
  typedef enum logic [4:0] {
    FTOI_IDLE   = 5'd16,
    FTOI_UNPACK = 5'd17,
    FTOI_ALIGN  = 5'd18,
    FTOI_FIX    = 5'd19,
    FTOI_DONE   = 5'd20
  } ftoi_state_e;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_BIG,
    CLS_INF,
    CLS_NAN
  } ftoi_cls_e;

endpackage

// File: rtl/fpu_ftoi_align.sv
// Barrel shifter aligning {1,mant} to an integer by unbiased exponent e.
// FTOI_RNE_EN adds guard and sticky outputs for rounding.
module ftoi_align
  import fpu_ftoi_pkg::*;
#(
  parameter int MAG_W = INT_W + 1
) (
  input  logic [7:0]        i_m,
  input  logic signed [8:0] i_e,
  output logic [MAG_W-1:0]  o_mag
`ifdef FTOI_RNE_EN
  ,
  output logic              o_guard,
  output logic              o_sticky
`endif
);

  localparam logic signed [8:0] E_SAT = 9'(MAG_W - 1);

  logic [4:0] w_lsh;
  logic [3:0] w_rsh;

  assign w_lsh = 5'(i_e - 9'sd7);
  assign w_rsh = 4'd7 - i_e[3:0];

`ifdef FTOI_RNE_EN
  logic [23:0] w_t;
  assign w_t = {i_m, 16'b0} >> w_rsh;
`endif

  always_comb begin
    o_mag = '0;
`ifdef FTOI_RNE_EN
    o_guard  = 1'b0;
    o_sticky = 1'b0;
`endif
    unique case (1'b1)
      (i_e >= E_SAT):
        o_mag = MAG_W'(i_m);
      (i_e >= 9'sd7 && i_e < E_SAT):
        o_mag = MAG_W'(i_m) << w_lsh;
      (i_e >= -9'sd8 && i_e < 9'sd7): begin
`ifdef FTOI_RNE_EN
        o_mag    = MAG_W'(w_t[23:16]);
        o_guard  = w_t[15];
        o_sticky = |w_t[14:0];
`else
        o_mag = MAG_W'(i_m >> w_rsh);
`endif
      end
      default: begin
`ifdef FTOI_RNE_EN
        o_sticky = |i_m;
`endif
      end
    endcase
  end

endmodule

// File: rtl/fpu_ftoi.sv
// PinKY float16 -> int16 converter, 4-cycle en/done handshake.
// Build with FTOI_RNE_EN for round-to-nearest-even instead of truncation.
module fpu_ftoi #(
  parameter int EXP_BIAS = fpu_ftoi_pkg::EXP_BIAS,
  parameter int INT_W    = fpu_ftoi_pkg::INT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [15:0]      op,
  output logic [INT_W-1:0] result,
  output logic             done,
  output logic             ovf
);
  import fpu_ftoi_pkg::*;

  localparam int MAG_W = INT_W + 1;
  localparam logic [MAG_W-1:0] POS_LIM = MAG_W'((1 << (INT_W - 1)) - 1);
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1 << (INT_W - 1));
  localparam logic [INT_W-1:0] SAT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SAT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic signed [8:0] E_BIG  = 9'(INT_W);

  ftoi_state_e r_state, w_next;

  logic [15:0]       r_op;
  logic              r_sign;
  logic [7:0]        r_m;
  logic signed [8:0] r_e;
  ftoi_cls_e         r_cls;
  logic [MAG_W-1:0]  r_mag;
  logic [INT_W-1:0]  r_res;
  logic              r_ovf;

  logic [7:0]        w_exp;
  logic [6:0]        w_mant;
  logic signed [8:0] w_e;
  ftoi_cls_e         w_cls;
  logic [MAG_W-1:0]  w_mag;
  logic [MAG_W-1:0]  w_rmag;
  logic [INT_W-1:0]  w_fres;
  logic              w_fovf;

  assign w_exp  = r_op[EXP_HI:EXP_LO];
  assign w_mant = r_op[MANT_HI:MANT_LO];
  assign w_e    = 9'($signed({1'b0, w_exp}) - EXP_BIAS);

  always_comb begin
    w_cls = CLS_NORM;
    if (w_exp == 8'd0)
      w_cls = CLS_ZERO;
    else if (w_exp == 8'hFF)
      w_cls = (w_mant == 7'd0) ? CLS_INF : CLS_NAN;
    else if (w_e >= E_BIG)
      w_cls = CLS_BIG;
  end

`ifdef FTOI_RNE_EN
  logic w_guard, w_sticky;
  logic r_guard, r_sticky;

  ftoi_align #(.MAG_W(MAG_W)) u_align (
    .i_m      (r_m),
    .i_e      (r_e),
    .o_mag    (w_mag),
    .o_guard  (w_guard),
    .o_sticky (w_sticky)
  );

  assign w_rmag = r_mag + MAG_W'(r_guard & (r_sticky | r_mag[0]));
`else
  ftoi_align #(.MAG_W(MAG_W)) u_align (
    .i_m   (r_m),
    .i_e   (r_e),
    .o_mag (w_mag)
  );

  assign w_rmag = r_mag;
`endif

  always_comb begin
    w_fres = '0;
    w_fovf = 1'b0;
    unique case (r_cls)
      CLS_ZERO: w_fovf = 1'b0;
      CLS_NAN:  w_fovf = 1'b1;
      CLS_INF, CLS_BIG: begin
        w_fres = r_sign ? SAT_MIN : SAT_MAX;
        w_fovf = 1'b1;
      end
      default: begin
        if (!r_sign && w_rmag > POS_LIM) begin
          w_fres = SAT_MAX;
          w_fovf = 1'b1;
        end else if (r_sign && w_rmag > NEG_LIM) begin
          w_fres = SAT_MIN;
          w_fovf = 1'b1;
        end else if (r_sign) begin
          w_fres = INT_W'(-w_rmag);
        end else begin
          w_fres = w_rmag[INT_W-1:0];
        end
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FTOI_IDLE:   if (en) w_next = FTOI_UNPACK;
      FTOI_UNPACK: w_next = FTOI_ALIGN;
      FTOI_ALIGN:  w_next = FTOI_FIX;
      FTOI_FIX:    w_next = FTOI_DONE;
      FTOI_DONE:   w_next = FTOI_IDLE;
      default:     w_next = FTOI_IDLE;
    endcase
  end

  assign done = (r_state == FTOI_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FTOI_IDLE;
      r_op    <= '0;
      r_sign  <= 1'b0;
      r_m     <= '0;
      r_e     <= '0;
      r_cls   <= CLS_ZERO;
      r_mag   <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
`ifdef FTOI_RNE_EN
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == FTOI_IDLE && en)
        r_op <= op;
      if (r_state == FTOI_UNPACK) begin
        r_sign <= r_op[SIGN_BIT];
        r_m    <= {1'b1, w_mant};
        r_e    <= w_e;
        r_cls  <= w_cls;
      end
      if (r_state == FTOI_ALIGN) begin
        r_mag <= w_mag;
`ifdef FTOI_RNE_EN
        r_guard  <= w_guard;
        r_sticky <= w_sticky;
`endif
      end
      if (r_state == FTOI_FIX) begin
        r_res <= w_fres;
        r_ovf <= w_fovf;
      end
      if (r_state == FTOI_DONE) begin
        result <= r_res;
        ovf    <= r_ovf;
      end
    end
  end

endmodule
